// File: rtl/alu_issue_ctrl.sv
// Request/response wrapper around the combinational RV32I ALU: decodes funct3/funct7[5]/is_imm,
// drives the ALU for one cycle, then returns the captured result on a valid/ready channel.
module alu_issue_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_rs1,
   input  logic [WIDTH-1:0] req_rs2,
   input  logic [WIDTH-1:0] req_imm,
   input  logic             req_is_imm,
   input  logic [2:0]       req_funct3,
   input  logic             req_f7b5,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_result,
   output logic             resp_err,
   output logic [CNT_W-1:0] cnt_issued,
   output logic [CNT_W-1:0] cnt_illegal
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_RESP  = 2'd2;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SLT = 3'd5;
   localparam logic [2:0] OP_SLL = 3'd6;
   localparam logic [2:0] OP_SRL = 3'd7;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [2:0]       alu_op_q, alu_op_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_issued_q, cnt_issued_d;
   logic [CNT_W-1:0] cnt_illegal_q, cnt_illegal_d;

   logic [2:0]       dec_op;
   logic             dec_illegal;

   // Decode funct3/funct7[5]; funct3=011 and funct3=101 with funct7[5] set are flagged illegal.
   always_comb begin
      dec_op      = OP_ADD;
      dec_illegal = 1'b0;
      case (req_funct3)
         3'b000:  dec_op = (req_f7b5 && !req_is_imm) ? OP_SUB : OP_ADD;
         3'b001:  dec_op = OP_SLL;
         3'b010:  dec_op = OP_SLT;
         3'b011:  dec_illegal = 1'b1;
         3'b100:  dec_op = OP_XOR;
         3'b101: begin
            dec_op      = OP_SRL;
            dec_illegal = req_f7b5;
         end
         3'b110:  dec_op = OP_OR;
         3'b111:  dec_op = OP_AND;
         default: dec_op = OP_ADD;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      alu_op_d      = alu_op_q;
      result_d      = result_q;
      err_d         = err_q;
      cnt_issued_d  = cnt_issued_q;
      cnt_illegal_d = cnt_illegal_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (dec_illegal) begin
                  state_d  = S_RESP;
                  result_d = '0;
                  err_d    = 1'b1;
                  if (cnt_illegal_q != {CNT_W{1'b1}})
                     cnt_illegal_d = cnt_illegal_q + CNT_W'(1);
               end else begin
                  state_d  = S_ISSUE;
                  alu_a_d  = req_rs1;
                  alu_b_d  = req_is_imm ? req_imm : req_rs2;
                  alu_op_d = dec_op;
                  if (cnt_issued_q != {CNT_W{1'b1}})
                     cnt_issued_d = cnt_issued_q + CNT_W'(1);
               end
            end
         end
         S_ISSUE: begin
            state_d  = S_RESP;
            result_d = alu_result;
            err_d    = 1'b0;
         end
         S_RESP: begin
            if (resp_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         alu_op_q      <= OP_ADD;
         result_q      <= '0;
         err_q         <= 1'b0;
         cnt_issued_q  <= '0;
         cnt_illegal_q <= '0;
      end else begin
         state_q       <= state_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         alu_op_q      <= alu_op_d;
         result_q      <= result_d;
         err_q         <= err_d;
         cnt_issued_q  <= cnt_issued_d;
         cnt_illegal_q <= cnt_illegal_d;
      end
   end

   assign req_ready   = (state_q == S_IDLE);
   assign resp_valid  = (state_q == S_RESP);
   assign resp_result = result_q;
   assign resp_err    = err_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_op      = alu_op_q;
   assign cnt_issued  = cnt_issued_q;
   assign cnt_illegal = cnt_illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a 16-bit-counter instance and a 2-bit-counter instance
// share the same stimulus so counter saturation is observed alongside normal operation.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [31:0] req_rs1, req_rs2, req_imm;
   logic        req_is_imm;
   logic [2:0]  req_funct3;
   logic        req_f7b5;
   logic        resp_ready;

   logic        req_ready, resp_valid, resp_err;
   logic [31:0] alu_a, alu_b, alu_result, resp_result;
   logic [2:0]  alu_op;
   logic [15:0] cnt_issued, cnt_illegal;

   logic        s_req_ready, s_resp_valid, s_resp_err;
   logic [31:0] s_alu_a, s_alu_b, s_alu_result, s_resp_result;
   logic [2:0]  s_alu_op;
   logic [1:0]  s_cnt_issued, s_cnt_illegal;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_a, exp_b;
   logic [2:0]  exp_op;
   int          exp_iss, exp_ill;

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return {31'd0, $signed(a) < $signed(b)};
         3'd6:    return a << b[4:0];
         default: return a >> b[4:0];
      endcase
   endfunction

   assign alu_result   = alu_f(alu_a, alu_b, alu_op);
   assign s_alu_result = alu_f(s_alu_a, s_alu_b, s_alu_op);

   alu_issue_ctrl #(.WIDTH(32), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm), .req_is_imm(req_is_imm),
      .req_funct3(req_funct3), .req_f7b5(req_f7b5),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
      .resp_err(resp_err), .cnt_issued(cnt_issued), .cnt_illegal(cnt_illegal)
   );

   alu_issue_ctrl #(.WIDTH(32), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
      .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm), .req_is_imm(req_is_imm),
      .req_funct3(req_funct3), .req_f7b5(req_f7b5),
      .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_op(s_alu_op), .alu_result(s_alu_result),
      .resp_valid(s_resp_valid), .resp_ready(resp_ready), .resp_result(s_resp_result),
      .resp_err(s_resp_err), .cnt_issued(s_cnt_issued), .cnt_illegal(s_cnt_illegal)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_counters(input string tag);
      chk({tag, ".cnt_issued"},  32'(cnt_issued),  32'(exp_iss));
      chk({tag, ".cnt_illegal"}, 32'(cnt_illegal), 32'(exp_ill));
      chk({tag, ".sat_issued"},  32'(s_cnt_issued),  32'((exp_iss > 3) ? 3 : exp_iss));
      chk({tag, ".sat_illegal"}, 32'(s_cnt_illegal), 32'((exp_ill > 3) ? 3 : exp_ill));
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, ".req_ready"},   32'(req_ready),  32'd1);
      chk({tag, ".resp_valid"},  32'(resp_valid), 32'd0);
      chk({tag, ".resp_err"},    32'(resp_err),   32'd0);
      chk({tag, ".resp_result"}, resp_result,     32'd0);
      chk({tag, ".alu_a"},       alu_a,           32'd0);
      chk({tag, ".alu_b"},       alu_b,           32'd0);
      chk({tag, ".alu_op"},      32'(alu_op),     32'd0);
      chk_counters(tag);
   endtask

   // One full transaction; 'hold' cycles of resp_ready=0 with a competing request on the bus.
   task automatic do_req(input string tag, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic is_imm, input logic [2:0] f3,
                         input logic f7b5, input logic ill, input logic [2:0] xop,
                         input logic [31:0] xres, input int hold);
      @(negedge clk);
      chk({tag, ".accept_ready"}, 32'(req_ready), 32'd1);
      req_rs1 = rs1; req_rs2 = rs2; req_imm = imm; req_is_imm = is_imm;
      req_funct3 = f3; req_f7b5 = f7b5; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      if (!ill) begin
         exp_iss++;
         exp_a  = rs1;
         exp_b  = is_imm ? imm : rs2;
         exp_op = xop;
         chk({tag, ".issue_resp_valid"}, 32'(resp_valid), 32'd0);
         chk({tag, ".issue_req_ready"},  32'(req_ready),  32'd0);
         chk({tag, ".issue_alu_a"},      alu_a,           exp_a);
         chk({tag, ".issue_alu_b"},      alu_b,           exp_b);
         chk({tag, ".issue_alu_op"},     32'(alu_op),     32'(exp_op));
         @(negedge clk);
      end else begin
         exp_ill++;
      end
      chk({tag, ".resp_valid"},  32'(resp_valid), 32'd1);
      chk({tag, ".resp_result"}, resp_result,     xres);
      chk({tag, ".resp_err"},    32'(resp_err),   32'(ill));
      chk({tag, ".alu_a_hold"},  alu_a,           exp_a);
      chk({tag, ".alu_b_hold"},  alu_b,           exp_b);
      chk({tag, ".alu_op_hold"}, 32'(alu_op),     32'(exp_op));
      chk_counters(tag);
      for (int i = 0; i < hold; i++) begin
         req_rs1 = 32'hDEAD_0000 + 32'(i); req_rs2 = 32'h1234; req_is_imm = 1'b0;
         req_funct3 = 3'b000; req_f7b5 = 1'b0; req_valid = 1'b1;
         @(negedge clk);
         chk({tag, ".bp_resp_valid"},  32'(resp_valid), 32'd1);
         chk({tag, ".bp_resp_result"}, resp_result,     xres);
         chk({tag, ".bp_req_ready"},   32'(req_ready),  32'd0);
         chk({tag, ".bp_alu_a"},       alu_a,           exp_a);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk({tag, ".done_resp_valid"}, 32'(resp_valid), 32'd0);
      chk({tag, ".done_req_ready"},  32'(req_ready),  32'd1);
      chk_counters({tag, ".done"});
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
      req_rs1 = '0; req_rs2 = '0; req_imm = '0; req_is_imm = 1'b0;
      req_funct3 = '0; req_f7b5 = 1'b0;
      exp_a = '0; exp_b = '0; exp_op = '0; exp_iss = 0; exp_ill = 0;
      repeat (2) @(negedge clk);
      chk_reset_state("reset");
      rst = 1'b0;

      do_req("add",  32'd10, 32'd5, 32'd0, 1'b0, 3'b000, 1'b0, 1'b0, 3'd0, 32'd15, 0);
      do_req("sub",  32'd10, 32'd5, 32'd0, 1'b0, 3'b000, 1'b1, 1'b0, 3'd1, 32'd5,  0);
      do_req("addi", 32'd10, 32'd9, 32'd5, 1'b1, 3'b000, 1'b1, 1'b0, 3'd0, 32'd15, 0);
      do_req("sltu", 32'd3,  32'd4, 32'd0, 1'b0, 3'b011, 1'b0, 1'b1, 3'd0, 32'd0,  0);
      do_req("sra",  32'd3,  32'd4, 32'd0, 1'b0, 3'b101, 1'b1, 1'b1, 3'd0, 32'd0,  0);
      do_req("and",  32'h0000_F0F0, 32'h0000_0FF0, 32'd0, 1'b0, 3'b111, 1'b0, 1'b0, 3'd2,
             32'h0000_00F0, 0);
      do_req("or",   32'h0000_F000, 32'h0000_000F, 32'd0, 1'b0, 3'b110, 1'b0, 1'b0, 3'd3,
             32'h0000_F00F, 0);
      do_req("xor",  32'h0000_00FF, 32'h0000_000F, 32'd0, 1'b0, 3'b100, 1'b0, 1'b0, 3'd4,
             32'h0000_00F0, 0);
      do_req("slt",  32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 3'b010, 1'b0, 1'b0, 3'd5, 32'd1, 0);
      do_req("slli", 32'd3, 32'd99, 32'd4, 1'b1, 3'b001, 1'b0, 1'b0, 3'd6, 32'd48, 0);
      do_req("srl",  32'h8000_0000, 32'd31, 32'd0, 1'b0, 3'b101, 1'b0, 1'b0, 3'd7, 32'd1, 0);
      do_req("bp",   32'd1, 32'd2, 32'd0, 1'b0, 3'b000, 1'b0, 1'b0, 3'd0, 32'd3, 5);

      // Reset lands while the request is in ISSUE; nothing may come out afterwards.
      @(negedge clk);
      req_rs1 = 32'd7; req_rs2 = 32'd8; req_is_imm = 1'b0; req_funct3 = 3'b000;
      req_f7b5 = 1'b0; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rst_mid.in_issue", 32'(resp_valid), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_iss = 0; exp_ill = 0; exp_a = '0; exp_b = '0; exp_op = '0;
      chk_reset_state("rst_mid");
      repeat (2) begin
         @(negedge clk);
         chk("rst_mid.no_resp", 32'(resp_valid), 32'd0);
      end
      do_req("post_rst", 32'd7, 32'd8, 32'd0, 1'b0, 3'b000, 1'b0, 1'b0, 3'd0, 32'd15, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
